axi_lite_master: RTL and testbench

Converts the single-pulse request/done interface driven by the block-level stimulus into AXI4-Lite master channels (AW, W, B, AR, R). It sits directly downstream of the stimulus generator and upstream of the AXI-Lite slave register file. Write and read engines are independent, and each handles one outstanding transaction at a time.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_vld_hold.sv | 22 ++
 rtl/axi_lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite master.
package axi_lite_pkg;

  // AXI response codes carried on BRESP / RRESP
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access for every transaction
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_lite_vld_hold.sv
// VALID holding register: set by a load pulse, held until the channel
// handshake (valid & ready at a rising edge), then cleared.
module axi_lite_vld_hold (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic ready,
  output logic valid
);

  // Load wins so a new request is never lost; otherwise drop only on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns single-cycle write/read request pulses into
// AW/W/B and AR/R channel traffic. The write and read engines are fully
// independent and each carries at most one transaction at a time.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_done,
  output logic [1:0]              wr_resp,
  output logic                    wr_busy,

  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_done,
  output logic [1:0]              rd_resp,
  output logic                    rd_busy,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  import axi_lite_pkg::*;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic wr_load;
  logic rd_load;
  logic aw_ok;
  logic w_ok;
  logic wr_complete;
  logic rd_complete;

  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;

  // A request is only taken while its engine is idle; busy-time pulses are dropped
  assign wr_load = (w_state == W_IDLE) && wr_req;
  assign rd_load = (r_state == R_IDLE) && rd_req;

  // A channel is finished once its VALID is already gone or handshakes this edge
  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid  || m_axi_wready;

  assign wr_complete = (w_state == W_RESP) && m_axi_bvalid;
  assign rd_complete = (r_state == R_DATA) && m_axi_rvalid;

  axi_lite_vld_hold u_aw_vld (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (wr_load),
    .ready (m_axi_awready),
    .valid (m_axi_awvalid)
  );

  axi_lite_vld_hold u_w_vld (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (wr_load),
    .ready (m_axi_wready),
    .valid (m_axi_wvalid)
  );

  axi_lite_vld_hold u_ar_vld (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (rd_load),
    .ready (m_axi_arready),
    .valid (m_axi_arvalid)
  );

  // Write engine state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  // Write engine next state: leave SEND only when both AW and W are done
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_req) w_next = W_SEND;
      W_SEND:  if (aw_ok && w_ok) w_next = W_RESP;
      W_RESP:  if (m_axi_bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write engine state-decoded outputs
  always_comb begin
    m_axi_bready = (w_state == W_RESP);
    wr_busy      = (w_state != W_IDLE);
  end

  // Capture write address/data/strobe so they stay stable while VALID is up
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
    end else if (wr_load) begin
      m_axi_awaddr <= wr_addr;
      m_axi_wdata  <= wr_data;
      m_axi_wstrb  <= wr_strb;
    end
  end

  // Write completion: one-cycle done pulse, response held until next completion
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_done <= 1'b0;
      wr_resp <= RESP_OKAY;
    end else begin
      wr_done <= wr_complete;
      if (wr_complete) begin
        wr_resp <= m_axi_bresp;
      end
    end
  end

  // Read engine state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  // Read engine next state: address phase, then wait for the data beat
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_req) r_next = R_ADDR;
      R_ADDR:  if (m_axi_arvalid && m_axi_arready) r_next = R_DATA;
      R_DATA:  if (m_axi_rvalid) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read engine state-decoded outputs
  always_comb begin
    m_axi_rready = (r_state == R_DATA);
    rd_busy      = (r_state != R_IDLE);
  end

  // Capture read address so it stays stable while ARVALID is up
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_araddr <= '0;
    end else if (rd_load) begin
      m_axi_araddr <= rd_addr;
    end
  end

  // Read completion: one-cycle done pulse, data and response held until next read
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_done <= 1'b0;
      rd_data <= '0;
      rd_resp <= RESP_OKAY;
    end else begin
      rd_done <= rd_complete;
      if (rd_complete) begin
        rd_data <= m_axi_rdata;
        rd_resp <= m_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a behavioural AXI-Lite slave with
// programmable per-channel wait states, a vector table for single
// transactions, and directed sequences for busy, concurrency and reset cases.
module tb_axi_lite_master;

  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          aclk;
  logic          aresetn;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_done;
  logic [1:0]    wr_resp;
  logic          wr_busy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_done;
  logic [1:0]    rd_resp;
  logic          rd_busy;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_resp(wr_resp), .wr_busy(wr_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .rd_resp(rd_resp), .rd_busy(rd_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // 100 MHz clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;

  // Slave wait-state knobs, set by the stimulus between transactions
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

  // Observation counters maintained by the monitor and slave
  int cyc = 0;
  int wr_done_total = 0, rd_done_total = 0;
  int aw_hi_total = 0, w_hi_total = 0, ar_hi_total = 0;
  int aw_hs_total = 0, ar_hs_total = 0;
  int last_wr_done_cyc = 0, last_rd_done_cyc = 0;
  int proto_err = 0;

  // Snapshots taken when a request is issued
  int aw_hi_base, w_hi_base, ar_hi_base, aw_hs_base, wr_done_base, rd_done_base;

  logic [31:0] mem [16];

  // Cycle counter
  always @(posedge aclk) cyc++;

  // Monitor: sample DUT outputs mid-cycle, count pulses and VALID-high cycles
  always @(negedge aclk) begin
    if (wr_done) begin
      wr_done_total++;
      last_wr_done_cyc = cyc;
    end
    if (rd_done) begin
      rd_done_total++;
      last_rd_done_cyc = cyc;
    end
    if (m_axi_awvalid) aw_hi_total++;
    if (m_axi_wvalid)  w_hi_total++;
    if (m_axi_arvalid) ar_hi_total++;
  end

  // Behavioural AXI-Lite slave, acting 1 time unit after each rising edge
  initial begin : slave
    bit          pend_aw, pend_w, pend_ar, b_allowed, r_allowed;
    bit          aw_v_prev, w_v_prev, ar_v_prev, b_rdy_prev, r_rdy_prev;
    logic [31:0] aw_addr_prev, ar_addr_prev, w_data_prev, pend_awaddr, pend_araddr, pend_wdata;
    logic [3:0]  w_strb_prev, pend_wstrb;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, idx;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    pend_aw = 0; pend_w = 0; pend_ar = 0; b_allowed = 0; r_allowed = 0;
    aw_v_prev = 0; w_v_prev = 0; ar_v_prev = 0; b_rdy_prev = 0; r_rdy_prev = 0;
    aw_addr_prev = 0; ar_addr_prev = 0; w_data_prev = 0; w_strb_prev = 0;
    pend_awaddr = 0; pend_araddr = 0; pend_wdata = 0; pend_wstrb = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; idx = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        pend_aw = 0; pend_w = 0; pend_ar = 0; b_allowed = 0; r_allowed = 0;
        aw_v_prev = 0; w_v_prev = 0; ar_v_prev = 0; b_rdy_prev = 0; r_rdy_prev = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (m_axi_awready && aw_v_prev) begin
          aw_hs_total++; pend_aw = 1; pend_awaddr = aw_addr_prev;
          m_axi_awready = 0; aw_cnt = 0;
        end else if (aw_v_prev && !(m_axi_awvalid && m_axi_awaddr == aw_addr_prev)) begin
          proto_err++;
        end
        if (m_axi_wready && w_v_prev) begin
          pend_w = 1; pend_wdata = w_data_prev; pend_wstrb = w_strb_prev;
          m_axi_wready = 0; w_cnt = 0;
        end else if (w_v_prev && !(m_axi_wvalid && m_axi_wdata == w_data_prev &&
                                   m_axi_wstrb == w_strb_prev)) begin
          proto_err++;
        end
        if (m_axi_bvalid && b_rdy_prev) begin
          m_axi_bvalid = 0; b_allowed = 0;
        end
        if (m_axi_arready && ar_v_prev) begin
          ar_hs_total++; pend_ar = 1; pend_araddr = ar_addr_prev;
          m_axi_arready = 0; ar_cnt = 0; r_allowed = 1;
        end else if (ar_v_prev && !(m_axi_arvalid && m_axi_araddr == ar_addr_prev)) begin
          proto_err++;
        end
        if (m_axi_rvalid && r_rdy_prev) begin
          m_axi_rvalid = 0; r_allowed = 0;
        end
        if (pend_aw && pend_w) b_allowed = 1;
        if (m_axi_bready && !b_allowed) proto_err++;
        if (m_axi_rready && !r_allowed) proto_err++;

        if (m_axi_awvalid && !m_axi_awready) begin
          if (aw_cnt >= aw_dly) m_axi_awready = 1; else aw_cnt++;
        end
        if (m_axi_wvalid && !m_axi_wready) begin
          if (w_cnt >= w_dly) m_axi_wready = 1; else w_cnt++;
        end
        if (m_axi_arvalid && !m_axi_arready) begin
          if (ar_cnt >= ar_dly) m_axi_arready = 1; else ar_cnt++;
        end
        if (pend_aw && pend_w && !m_axi_bvalid) begin
          if (b_cnt >= b_dly) begin
            idx = int'(pend_awaddr[5:2]);
            for (int k = 0; k < 4; k++)
              if (pend_wstrb[k]) mem[idx][8*k +: 8] = pend_wdata[8*k +: 8];
            m_axi_bresp  = (pend_awaddr == 32'h10) ? RESP_SLVERR : RESP_OKAY;
            m_axi_bvalid = 1; pend_aw = 0; pend_w = 0; b_cnt = 0;
          end else begin
            b_cnt++;
          end
        end
        if (pend_ar && !m_axi_rvalid) begin
          if (r_cnt >= r_dly) begin
            idx = int'(pend_araddr[5:2]);
            m_axi_rdata  = mem[idx];
            m_axi_rresp  = (pend_araddr == 32'h14) ? RESP_DECERR : RESP_OKAY;
            m_axi_rvalid = 1; pend_ar = 0; r_cnt = 0;
          end else begin
            r_cnt++;
          end
        end

        aw_v_prev = m_axi_awvalid; aw_addr_prev = m_axi_awaddr;
        w_v_prev  = m_axi_wvalid;  w_data_prev = m_axi_wdata; w_strb_prev = m_axi_wstrb;
        ar_v_prev = m_axi_arvalid; ar_addr_prev = m_axi_araddr;
        b_rdy_prev = m_axi_bready; r_rdy_prev = m_axi_rready;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Pulse the request(s) for exactly one rising edge
  task automatic applyStimulus(input bit do_wr, input bit do_rd, input logic [31:0] waddr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic [31:0] raddr);
    @(negedge aclk);
    wr_req = do_wr; wr_addr = waddr; wr_data = wdata; wr_strb = wstrb;
    rd_req = do_rd; rd_addr = raddr;
    #1;
    aw_hi_base = aw_hi_total; w_hi_base = w_hi_total; ar_hi_base = ar_hi_total;
    aw_hs_base = aw_hs_total; wr_done_base = wr_done_total; rd_done_base = rd_done_total;
    @(negedge aclk);
    wr_req = 0; rd_req = 0;
  endtask

  // Count negedges until the done pulse is seen, bounded by budget
  task automatic wait_done(input string name, input bit is_wr, input int budget, output int lat);
    bit seen = 0;
    lat = 0;
    while (!seen && lat < budget) begin
      @(negedge aclk);
      lat++;
      seen = is_wr ? wr_done : rd_done;
    end
    checkOutput({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    #1;
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] exp_resp);
    int lat;
    applyStimulus(1, 0, addr, data, 4'hF, 32'h0);
    wait_done(name, 1, 40, lat);
    checkOutput({name, "_wr_resp"}, {30'b0, wr_resp}, {30'b0, exp_resp});
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data);
    int lat;
    applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, addr);
    wait_done(name, 0, 40, lat);
    checkOutput({name, "_rd_data"}, rd_data, exp_data);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  exp_resp;
    logic [1:0]  exp_other;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_vcyc;
    int          exp_wcyc;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    int lat;
    int n;
    //          wr addr      data          strb  aw w  b  ar r  resp         other        rdata         lat vc wc
    vecs[0] = '{1, 32'h00, 32'hABCD1234, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   32'h0,        2, 1, 1};
    vecs[1] = '{0, 32'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   32'hABCD1234, 2, 1, 0};
    vecs[2] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, RESP_SLVERR, RESP_OKAY,   32'h0,        2, 1, 1};
    vecs[3] = '{0, 32'h14, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_DECERR, RESP_SLVERR, 32'h0,        2, 1, 0};
    vecs[4] = '{1, 32'h18, 32'h12345678, 4'h5, 1, 2, 1, 0, 0, RESP_OKAY,   RESP_DECERR, 32'h0,        5, 2, 3};
    vecs[5] = '{0, 32'h18, 32'h0,        4'h0, 0, 0, 0, 2, 1, RESP_OKAY,   RESP_OKAY,   32'h00340078, 5, 3, 0};
    vecs[6] = '{1, 32'h1C, 32'hCAFEF00D, 4'h8, 3, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   32'h0,        5, 4, 1};
    vecs[7] = '{0, 32'h1C, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   RESP_OKAY,   32'hCA000000, 2, 1, 0};
    vecs[8] = '{1, 32'h00, 32'h00005500, 4'h2, 0, 4, 2, 0, 0, RESP_OKAY,   RESP_OKAY,   32'h0,        8, 1, 5};
    vecs[9] = '{0, 32'h00, 32'h0,        4'h0, 0, 0, 0, 0, 3, RESP_OKAY,   RESP_OKAY,   32'hABCD5534, 5, 1, 0};

    aresetn = 0; wr_req = 0; rd_req = 0;
    wr_addr = 0; wr_data = 0; wr_strb = 0; rd_addr = 0;
    repeat (3) @(negedge aclk);

    $display("[TB] checking reset state");
    checkOutput("reset_ctrl",
                {22'b0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                 wr_done, rd_done, wr_busy, rd_busy, m_axi_awprot == 3'b000}, 32'd1);
    checkOutput("reset_resp", {28'b0, wr_resp, rd_resp}, 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);
    checkOutput("reset_addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'd0);
    aresetn = 1;
    @(negedge aclk);

    $display("[TB] running vector table");
    for (int i = 0; i < NV; i++) begin
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
      ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d;
      applyStimulus(vecs[i].is_wr, !vecs[i].is_wr, vecs[i].addr, vecs[i].data,
                    vecs[i].strb, vecs[i].addr);
      wait_done($sformatf("v%0d", i), vecs[i].is_wr, 40, lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].is_wr) begin
        checkOutput($sformatf("v%0d_wr_resp", i), {30'b0, wr_resp}, {30'b0, vecs[i].exp_resp});
        checkOutput($sformatf("v%0d_rd_resp_held", i), {30'b0, rd_resp}, {30'b0, vecs[i].exp_other});
        checkOutput($sformatf("v%0d_awvalid_cycles", i), 32'(aw_hi_total - aw_hi_base),
                    32'(vecs[i].exp_vcyc));
        checkOutput($sformatf("v%0d_wvalid_cycles", i), 32'(w_hi_total - w_hi_base),
                    32'(vecs[i].exp_wcyc));
        checkOutput($sformatf("v%0d_wr_busy", i), {31'b0, wr_busy}, 32'd0);
      end else begin
        checkOutput($sformatf("v%0d_rd_resp", i), {30'b0, rd_resp}, {30'b0, vecs[i].exp_resp});
        checkOutput($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rdata);
        checkOutput($sformatf("v%0d_wr_resp_held", i), {30'b0, wr_resp}, {30'b0, vecs[i].exp_other});
        checkOutput($sformatf("v%0d_arvalid_cycles", i), 32'(ar_hi_total - ar_hi_base),
                    32'(vecs[i].exp_vcyc));
        checkOutput($sformatf("v%0d_rd_busy", i), {31'b0, rd_busy}, 32'd0);
      end
      @(negedge aclk);
      checkOutput($sformatf("v%0d_done_one_cycle", i), {30'b0, wr_done, rd_done}, 32'd0);
    end

    $display("[TB] write request while busy");
    aw_dly = 3; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    applyStimulus(1, 0, 32'h20, 32'h55AA55AA, 4'hF, 32'h0);
    @(negedge aclk);
    wr_req = 1; wr_addr = 32'h08; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
    @(negedge aclk);
    wr_req = 0;
    checkOutput("busy_awaddr_stable", m_axi_awaddr, 32'h20);
    checkOutput("busy_wdata_stable", m_axi_wdata, 32'h55AA55AA);
    wait_done("busy", 1, 40, lat);
    repeat (5) @(negedge aclk);
    checkOutput("busy_aw_handshakes", 32'(aw_hs_total - aw_hs_base), 32'd1);
    checkOutput("busy_wr_done_count", 32'(wr_done_total - wr_done_base), 32'd1);
    aw_dly = 0;
    do_read("busy_rd08", 32'h08, 32'h0);
    do_read("busy_rd20", 32'h20, 32'h55AA55AA);

    $display("[TB] concurrent write and read");
    r_dly = 5;
    applyStimulus(1, 1, 32'h04, 32'h11111111, 4'hF, 32'h0C);
    n = 0;
    while (n < 40 && !(wr_done_total > wr_done_base && rd_done_total > rd_done_base)) begin
      @(negedge aclk);
      n++;
    end
    #1;
    checkOutput("conc_wr_done_count", 32'(wr_done_total - wr_done_base), 32'd1);
    checkOutput("conc_rd_done_count", 32'(rd_done_total - rd_done_base), 32'd1);
    checkOutput("conc_rd_after_wr", 32'(last_rd_done_cyc - last_wr_done_cyc), 32'd5);
    checkOutput("conc_rd_data", rd_data, 32'h0);
    checkOutput("conc_resps", {28'b0, wr_resp, rd_resp}, 32'd0);
    r_dly = 0;
    do_read("conc_rd04", 32'h04, 32'h11111111);

    $display("[TB] reset during read data phase");
    r_dly = 10;
    applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h08);
    n = 0;
    while (n < 20 && !m_axi_rready) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("rst_rready_reached", {31'b0, m_axi_rready}, 32'd1);
    @(negedge aclk);
    rd_done_base = rd_done_total;
    aresetn = 0;
    #1;
    checkOutput("rst_drops_ctrl", {28'b0, m_axi_rready, m_axi_arvalid, rd_busy, rd_done}, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1;
    repeat (15) @(negedge aclk);
    #1;
    checkOutput("rst_no_rd_done", 32'(rd_done_total - rd_done_base), 32'd0);
    r_dly = 0;
    do_write("rst_wr08", 32'h08, 32'h0BADCAFE, RESP_OKAY);
    do_read("rst_rd08", 32'h08, 32'h0BADCAFE);

    repeat (3) @(negedge aclk);
    checkOutput("protocol_errors", 32'(proto_err), 32'd0);
    checkOutput("total_wr_done", 32'(wr_done_total), 32'd8);
    checkOutput("total_rd_done", 32'(rd_done_total), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
